butter_lp_chan_sched: RTL and testbench
=======================================

// Module: butter_lp_chan_sched
// PURPOSE
// - Time-multiplexes one first-order Butterworth LP datapath across N_CH AXI-Stream channels.
// - Round-robin arbitration; per-channel x_past/y_past banks; one shared 32x32 multiplier used over 3 cycles.
// - Sits between the multi-channel acquisition front end and downstream HSS feature extraction.
// - Output is tagged with the source channel.
// PARAMETERS
// - N_CH       4                  number of input channels (2..16)
// - CH_W       2                  channel-id width, $clog2(N_CH)
// - FRAC_BITS  12                 fractional bits of the 3.12 coefficients
// - COEFF_FILE `BUTTER_COEFF_FILE hex file for c0,c1,c2; loaded with $readmemh
// PORTS
// - aclk           in   1         clock
// - aresetn        in   1         reset, synchronous, active-low
// - s_axis_tdata   in   N_CH*32   signed samples; ch k in bits [32k+31:32k]
// - s_axis_tvalid  in   N_CH      per-channel valid
// - s_axis_tready  out  N_CH      per-channel ready; one-hot or zero
// - m_axis_tdata   out  32        filtered sample y
// - m_axis_tuser   out  CH_W      channel id of m_axis_tdata
// - m_axis_tvalid  out  1         output valid
// - m_axis_tready  in   1         downstream ready
// - busy           out  1         high in any state other than IDLE
// BEHAVIOUR
// - Reset (aresetn=0 at posedge): state=IDLE; rr_ptr=N_CH-1; all x_past/y_past=0; m_axis_tdata=0;
//   m_axis_tuser=0; m_axis_tvalid=0; busy=0; s_axis_tready=0. Coefficients unaffected by reset.
// - Reset mid-operation aborts the transaction: no output, and that channel's state is cleared like the others.
// - FSM: IDLE -> MAC0 -> MAC1 -> MAC2 -> OUT -> IDLE.
// - IDLE: grant g = first channel with tvalid=1, searching from rr_ptr+1 modulo N_CH.
//   - s_axis_tready[g]=1 (combinational from tvalid, allowed by AXI).
//   - On that edge: latch x=tdata[g], ch=g, rr_ptr=g; go to MAC0.
//   - With no valid, stay in IDLE with s_axis_tready=0.
// - MAC0: acc  = c0*x            (64-bit signed)
// - MAC1: acc += c1*x_past[ch]
// - MAC2: acc -= c2*y_past[ch]
//   - y = (acc >>> FRAC_BITS)[31:0]; truncation wraps, no saturation.
//   - On the MAC2 edge: m_axis_tdata=y, m_axis_tuser=ch, m_axis_tvalid=1, x_past[ch]=x, y_past[ch]=y; go to OUT.
// - OUT: hold tdata, tuser and tvalid stable until m_axis_tready=1; on that edge tvalid=0 and state=IDLE.
// - Latency: input accepted at edge E; m_axis_tvalid=1 after edge E+3.
//   - Minimum period is 5 cycles per sample; no new accept while busy.
// - Arbitration is work-conserving: a channel waits at most N_CH-1 grants.
// - Non-granted channels and all channels outside IDLE see tready=0; their tdata must be held (AXI rule).
// CONFIGURATION
// - Macro BUTTER_SCHED_COEFF_WR_EN:
//   - Defined: adds ports cfg_we (in,1), cfg_addr (in,2), cfg_wdata (in,32).
//     - In IDLE, cfg_we=1 writes coeff[cfg_addr] (addr 3 ignored).
//     - The write wins over arbitration that cycle: s_axis_tready=0 and rr_ptr unchanged.
//     - cfg_we is ignored outside IDLE; hold it until busy=0.
//   - Undefined: those ports are absent; coefficients are constant from COEFF_FILE.
// TESTING (coeffs c0=0x800, c1=0x800, c2=0xFFFFF800, i.e. 0.5, 0.5, -0.5)
// - Impulse ch0: x=1000,0,0 -> y=500,750,375; tuser=0; tvalid 3 edges after each accept.
// - Isolation: ch0 x=1000 then ch1 x=0 then ch0 x=0 -> ch0 y=500, ch1 y=0, ch0 y=750; ch1 state untouched.
// - Fairness: all 4 valid continuously after reset -> grant order 0,1,2,3,0,1; one accept per 5 cycles.
// - Backpressure: m_axis_tready=0 for 10 cycles in OUT -> tdata/tuser/tvalid stable; s_axis_tready all 0.
// - Reset in MAC1 after ch2 x=1000 -> no output; the next ch2 x=0 gives y=0.
// - With BUTTER_SCHED_COEFF_WR_EN: write c0=0x1000, c1=0, c2=0 in IDLE -> ch3 x=-7 gives y=-7.
//   A cfg_we pulse during MAC0 leaves the coefficients unchanged.

Source files
------------

// File: rtl/butter_lp_chan_sched.sv
`default_nettype none
// ============================================================================
// Module   : butter_lp_chan_sched
// Brief    : Round-robin scheduler sharing one first-order Butterworth LP
//            datapath (one 32x32 signed multiplier over three MAC cycles)
//            across N_CH AXI-Stream channels. Output is tagged with the
//            source channel id.
// Config   : BUTTER_SCHED_COEFF_WR_EN - adds cfg_we/cfg_addr/cfg_wdata
//            for run-time coefficient writes while IDLE. Without it the
//            coefficients are the constants C0_INIT/C1_INIT/C2_INIT
//            (the values generated from the coefficient hex file).
// Revision : 1.0 - initial release
// ============================================================================
module butter_lp_chan_sched #(
  parameter int          N_CH      = 4,
  parameter int          CH_W      = $clog2(N_CH),
  parameter int          FRAC_BITS = 12,
  parameter logic [31:0] C0_INIT   = 32'h0000_0800,
  parameter logic [31:0] C1_INIT   = 32'h0000_0800,
  parameter logic [31:0] C2_INIT   = 32'hFFFF_F800
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [N_CH*32-1:0]  s_axis_tdata,
  input  logic [N_CH-1:0]     s_axis_tvalid,
  output logic [N_CH-1:0]     s_axis_tready,
  output logic [31:0]         m_axis_tdata,
  output logic [CH_W-1:0]     m_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
`ifdef BUTTER_SCHED_COEFF_WR_EN
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
`endif
  output logic                busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC0 = 3'd1,
    ST_MAC1 = 3'd2,
    ST_MAC2 = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CH_W-1:0]           r_rr_ptr;
  logic [CH_W-1:0]           r_ch;
  logic signed [31:0]        r_x;
  logic signed [63:0]        r_acc;
  logic signed [31:0]        r_x_past [N_CH];
  logic signed [31:0]        r_y_past [N_CH];
  logic [31:0]               r_m_tdata;
  logic [CH_W-1:0]           r_m_tuser;
  logic                      r_m_tvalid;

  logic                      w_found;
  logic [CH_W-1:0]           w_grant;
  logic                      w_accept;
  logic                      w_cfg_wr;
  logic signed [31:0]        w_c0;
  logic signed [31:0]        w_c1;
  logic signed [31:0]        w_c2;
  logic signed [31:0]        w_mul_a;
  logic signed [31:0]        w_mul_b;
  logic signed [63:0]        w_prod;
  logic signed [63:0]        w_acc_fin;
  logic signed [31:0]        w_y;

`ifdef BUTTER_SCHED_COEFF_WR_EN
  // Coefficients power up to the generated values and are not touched by reset.
  logic signed [31:0] r_c0 = C0_INIT;
  logic signed [31:0] r_c1 = C1_INIT;
  logic signed [31:0] r_c2 = C2_INIT;

  assign w_cfg_wr = aresetn && cfg_we && (r_state == ST_IDLE);
  assign w_c0     = r_c0;
  assign w_c1     = r_c1;
  assign w_c2     = r_c2;

  // Coefficient write port; address 3 is a hole and silently dropped.
  always_ff @(posedge aclk) begin
    if (w_cfg_wr) begin
      case (cfg_addr)
        2'd0:    r_c0 <= cfg_wdata;
        2'd1:    r_c1 <= cfg_wdata;
        2'd2:    r_c2 <= cfg_wdata;
        default: ;
      endcase
    end
  end
`else
  assign w_cfg_wr = 1'b0;
  assign w_c0     = C0_INIT;
  assign w_c1     = C1_INIT;
  assign w_c2     = C2_INIT;
`endif

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(r_rr_ptr) + i) % N_CH;
      if (!w_found && s_axis_tvalid[idx]) begin
        w_found = 1'b1;
        w_grant = CH_W'(idx);
      end
    end
  end

  // A config write in IDLE takes priority over granting a channel.
  assign w_accept = aresetn && w_found && !w_cfg_wr;

  // Operand select for the single shared multiplier, one term per MAC cycle.
  always_comb begin
    w_mul_a = w_c2;
    w_mul_b = r_y_past[r_ch];
    case (r_state)
      ST_MAC0: begin
        w_mul_a = w_c0;
        w_mul_b = r_x;
      end
      ST_MAC1: begin
        w_mul_a = w_c1;
        w_mul_b = r_x_past[r_ch];
      end
      default: ;
    endcase
  end

  assign w_prod    = w_mul_a * w_mul_b;
  assign w_acc_fin = r_acc - w_prod;
  // Truncating rescale: wraps on overflow, no saturation.
  assign w_y       = 32'(w_acc_fin >>> FRAC_BITS);

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic plus the handshake/status outputs that depend on state.
  always_comb begin
    w_state_nxt   = r_state;
    s_axis_tready = '0;
    busy          = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          s_axis_tready = {{(N_CH-1){1'b0}}, 1'b1} << w_grant;
          w_state_nxt   = ST_MAC0;
        end
      end
      ST_MAC0: w_state_nxt = ST_MAC1;
      ST_MAC1: w_state_nxt = ST_MAC2;
      ST_MAC2: w_state_nxt = ST_OUT;
      ST_OUT:  if (m_axis_tready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: sample capture, accumulation, history banks and output register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rr_ptr   <= CH_W'(N_CH - 1);
      r_ch       <= '0;
      r_x        <= '0;
      r_acc      <= '0;
      r_m_tdata  <= '0;
      r_m_tuser  <= '0;
      r_m_tvalid <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_x_past[k] <= '0;
        r_y_past[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x      <= s_axis_tdata[32*int'(w_grant) +: 32];
            r_ch     <= w_grant;
            r_rr_ptr <= w_grant;
          end
        end
        ST_MAC0: r_acc <= w_prod;
        ST_MAC1: r_acc <= r_acc + w_prod;
        ST_MAC2: begin
          r_m_tdata      <= w_y;
          r_m_tuser      <= r_ch;
          r_m_tvalid     <= 1'b1;
          r_x_past[r_ch] <= r_x;
          r_y_past[r_ch] <= w_y;
        end
        ST_OUT: if (m_axis_tready) r_m_tvalid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tvalid = r_m_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_butter_lp_chan_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_butter_lp_chan_sched
// Brief    : Directed self-checking bench for butter_lp_chan_sched with
//            coefficients 0.5, 0.5, -0.5 (3.12 format).
// Revision : 1.0 - initial release
// ============================================================================
module tb_butter_lp_chan_sched;
  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic                aclk = 1'b0;
  logic                aresetn;
  logic [N_CH*32-1:0]  s_axis_tdata;
  logic [N_CH-1:0]     s_axis_tvalid;
  logic [N_CH-1:0]     s_axis_tready;
  logic [31:0]         m_axis_tdata;
  logic [CH_W-1:0]     m_axis_tuser;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic                busy;
`ifdef BUTTER_SCHED_COEFF_WR_EN
  logic                cfg_we;
  logic [1:0]          cfg_addr;
  logic [31:0]         cfg_wdata;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  butter_lp_chan_sched #(.N_CH(N_CH), .CH_W(CH_W), .FRAC_BITS(12)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
`ifdef BUTTER_SCHED_COEFF_WR_EN
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
`endif
    .busy          (busy)
  );

  // 100 MHz clock.
  always #5 aclk = ~aclk;

  // Hard stop in case something hangs.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
`ifdef BUTTER_SCHED_COEFF_WR_EN
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
`endif
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  // Push one sample on channel ch, wait for the result; y is X on timeout.
  task automatic do_sample(input int ch, input logic [31:0] x,
                           output logic [31:0] y, output logic [CH_W-1:0] u,
                           output int lat);
    int cnt;
    y   = 'x;
    u   = 'x;
    lat = -1;
    s_axis_tdata[ch*32 +: 32] = x;
    s_axis_tvalid[ch]         = 1'b1;
    #1;
    cnt = 0;
    while (!s_axis_tready[ch] && cnt < 20) begin
      tick();
      cnt++;
    end
    if (cnt >= 20) begin
      s_axis_tvalid[ch] = 1'b0;
      return;
    end
    tick();
    s_axis_tvalid[ch] = 1'b0;
    cnt = 0;
    while (!m_axis_tvalid && cnt < 20) begin
      tick();
      cnt++;
    end
    if (!m_axis_tvalid) return;
    lat = cnt;
    y   = m_axis_tdata;
    u   = m_axis_tuser;
    tick();
  endtask

  task automatic test_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = '1;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    tick();
    tick();
    #1;
    n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b expected 0", m_axis_tvalid); end
    n_tests++; if (m_axis_tdata !== 32'd0) begin n_fail++; $display("FAIL rst_tdata: got %h expected 0", m_axis_tdata); end
    n_tests++; if (m_axis_tuser !== 2'd0) begin n_fail++; $display("FAIL rst_tuser: got %0d expected 0", m_axis_tuser); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_tests++; if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL rst_tready: got %b expected 0000", s_axis_tready); end
    aresetn = 1'b1;
    #1;
    n_tests++; if (s_axis_tready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_grant: got %b expected 0001", s_axis_tready); end
    s_axis_tvalid = '0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_impulse();
    int          xs [3] = '{1000, 0, 0};
    int          ys [3] = '{500, 750, 375};
    logic [31:0] y;
    logic [CH_W-1:0] u;
    int          lat;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      do_sample(0, xs[k], y, u, lat);
      n_tests++; if (y !== ys[k]) begin n_fail++; $display("FAIL impulse_y[%0d]: got %0d expected %0d", k, $signed(y), ys[k]); end
      n_tests++; if (u !== 2'd0) begin n_fail++; $display("FAIL impulse_tuser[%0d]: got %0d expected 0", k, u); end
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL impulse_latency[%0d]: got %0d expected 3", k, lat); end
    end
  endtask

  task automatic test_isolation();
    int          chs [6] = '{0, 1, 0, 1, 0, 1};
    int          xs  [6] = '{1000, 0, 0, 400, 0, 0};
    int          ys  [6] = '{500, 0, 750, 200, 375, 300};
    logic [31:0] y;
    logic [CH_W-1:0] u;
    int          lat;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      do_sample(chs[k], xs[k], y, u, lat);
      n_tests++; if (y !== ys[k]) begin n_fail++; $display("FAIL isolation_y[%0d]: got %0d expected %0d", k, $signed(y), ys[k]); end
      n_tests++; if (u !== CH_W'(chs[k])) begin n_fail++; $display("FAIL isolation_tuser[%0d]: got %0d expected %0d", k, u, chs[k]); end
    end
  endtask

  task automatic test_fairness();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    int got_g [6];
    int got_c [6];
    int n;
    int cyc;
    bit onehot_ok;
    apply_reset();
    for (int k = 0; k < 6; k++) begin got_g[k] = -1; got_c[k] = -1; end
    s_axis_tdata  = '0;
    s_axis_tvalid = '1;
    #1;
    n = 0;
    cyc = 0;
    onehot_ok = 1'b1;
    while (n < 6 && cyc < 60) begin
      if (!$onehot0(s_axis_tready)) onehot_ok = 1'b0;
      if (s_axis_tready != '0) begin
        for (int c = 0; c < N_CH; c++) if (s_axis_tready[c]) got_g[n] = c;
        got_c[n] = cyc;
        n++;
      end
      tick();
      cyc++;
    end
    s_axis_tvalid = '0;
    n_tests++; if (!onehot_ok) begin n_fail++; $display("FAIL fair_onehot: got non-one-hot tready expected one-hot or zero"); end
    for (int k = 0; k < 6; k++) begin
      n_tests++; if (got_g[k] !== exp_g[k]) begin n_fail++; $display("FAIL fair_grant[%0d]: got %0d expected %0d", k, got_g[k], exp_g[k]); end
    end
    for (int k = 1; k < 6; k++) begin
      n_tests++; if (got_c[k] - got_c[k-1] !== 5) begin n_fail++; $display("FAIL fair_period[%0d]: got %0d expected 5", k, got_c[k] - got_c[k-1]); end
    end
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_backpressure();
    int cnt;
    apply_reset();
    m_axis_tready         = 1'b0;
    s_axis_tdata[32 +: 32] = 32'd2000;
    s_axis_tvalid[1]      = 1'b1;
    #1;
    cnt = 0;
    while (!s_axis_tready[1] && cnt < 20) begin tick(); cnt++; end
    tick();
    s_axis_tvalid[1] = 1'b0;
    cnt = 0;
    while (!m_axis_tvalid && cnt < 20) begin tick(); cnt++; end
    s_axis_tvalid = '1;
    #1;
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1000 || m_axis_tuser !== 2'd1 ||
          s_axis_tready !== 4'b0000 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d u=%0d rdy=%b busy=%b expected v=1 d=1000 u=1 rdy=0000 busy=1",
                 k, m_axis_tvalid, $signed(m_axis_tdata), m_axis_tuser, s_axis_tready, busy);
      end
      tick();
    end
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
    tick();
    n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_release_tvalid: got %b expected 0", m_axis_tvalid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int          cnt;
    bit          saw_valid;
    logic [31:0] y;
    logic [CH_W-1:0] u;
    int          lat;
    apply_reset();
    s_axis_tdata[64 +: 32] = 32'd1000;
    s_axis_tvalid[2]       = 1'b1;
    #1;
    cnt = 0;
    while (!s_axis_tready[2] && cnt < 20) begin tick(); cnt++; end
    tick();
    s_axis_tvalid[2] = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_mac1: got %b expected 1", busy); end
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (m_axis_tvalid) saw_valid = 1'b1;
      tick();
    end
    n_tests++; if (saw_valid) begin n_fail++; $display("FAIL rmid_no_output: got tvalid=1 expected no output"); end
    n_tests++; if (m_axis_tdata !== 32'd0) begin n_fail++; $display("FAIL rmid_tdata: got %0d expected 0", $signed(m_axis_tdata)); end
    do_sample(2, 32'd0, y, u, lat);
    n_tests++; if (y !== 32'd0) begin n_fail++; $display("FAIL rmid_next_y: got %0d expected 0", $signed(y)); end
    n_tests++; if (u !== 2'd2) begin n_fail++; $display("FAIL rmid_next_tuser: got %0d expected 2", u); end
  endtask

`ifdef BUTTER_SCHED_COEFF_WR_EN
  task automatic test_cfg();
    logic [31:0] wd [3] = '{32'h0000_1000, 32'h0, 32'h0};
    logic [31:0] y;
    logic [CH_W-1:0] u;
    int          lat;
    int          cnt;
    apply_reset();
    s_axis_tdata  = '0;
    s_axis_tvalid = '1;
    for (int a = 0; a < 3; a++) begin
      cfg_we    = 1'b1;
      cfg_addr  = 2'(a);
      cfg_wdata = wd[a];
      #1;
      n_tests++; if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL cfg_write_blocks[%0d]: got %b expected 0000", a, s_axis_tready); end
      tick();
    end
    cfg_we = 1'b0;
    #1;
    n_tests++; if (s_axis_tready !== 4'b0001) begin n_fail++; $display("FAIL cfg_rr_unchanged: got %b expected 0001", s_axis_tready); end
    s_axis_tvalid = '0;
    do_sample(3, 32'hFFFF_FFF9, y, u, lat);
    n_tests++; if (y !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL cfg_y: got %0d expected -7", $signed(y)); end
    s_axis_tdata[96 +: 32] = 32'hFFFF_FFF9;
    s_axis_tvalid[3]       = 1'b1;
    #1;
    cnt = 0;
    while (!s_axis_tready[3] && cnt < 20) begin tick(); cnt++; end
    tick();
    s_axis_tvalid[3] = 1'b0;
    cfg_we    = 1'b1;
    cfg_addr  = 2'd0;
    cfg_wdata = 32'h0000_2000;
    tick();
    cfg_we = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    do_sample(3, 32'hFFFF_FFF9, y, u, lat);
    n_tests++; if (y !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL cfg_busy_ignored: got %0d expected -7", $signed(y)); end
  endtask
`endif

  initial begin
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
`ifdef BUTTER_SCHED_COEFF_WR_EN
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
`endif
    test_reset();
    test_impulse();
    test_isolation();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef BUTTER_SCHED_COEFF_WR_EN
    test_cfg();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
